// File: rtl/interp_lerp_engine_pkg.sv
// Shared definitions for the pilot interpolation engine: mode and FSM encodings, width helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package interp_pkg;

   typedef enum logic [1:0] {
      MODE_INTERP = 2'b00,
      MODE_EXTL   = 2'b01,
      MODE_EXTR   = 2'b10,
      MODE_HOLD   = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      DIFF = 2'b01,
      EMIT = 2'b10
   } state_e;

   // Accumulator carries SH fractional bits plus two guard bits above the output range,
   // enough for the extrap-right worst case before saturation.
   function automatic int acc_width(input int out_w, input int sh);
      return out_w + sh + 2;
   endfunction

   // Largest positive value of a signed out_w-bit result; the minimum is its complement.
   function automatic longint sat_max(input int out_w);
      return (longint'(1) <<< (out_w - 1)) - 1;
   endfunction

endpackage

// File: rtl/interp_lerp_engine_lane.sv
// One channel lane: latches Ea/Eb, forms d, runs the shift-add accumulator, rounds and saturates.
// Latency: output register loads in DIFF (first beat) and on each advance thereafter.
// Backpressure: accumulator and output hold whenever adv_i is low outside DIFF.
module interp_lane
   import interp_pkg::*;
#(
   parameter int IN_WIDTH  = 17,
   parameter int OUT_WIDTH = 19,
   parameter int SH        = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load_i,
   input  logic                 diff_i,
   input  logic                 adv_i,
   input  logic [1:0]           mode_i,
   input  logic [IN_WIDTH-1:0]  ea_i,
   input  logic [IN_WIDTH-1:0]  eb_i,
   output logic [OUT_WIDTH-1:0] out_o
);

   localparam int AW = acc_width(OUT_WIDTH, SH);
   localparam logic signed [AW-1:0] RND     = AW'(1 << (SH - 1));
   localparam logic signed [AW-1:0] SAT_MAX = AW'(sat_max(OUT_WIDTH));
   localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

   logic signed [IN_WIDTH-1:0]  ea_q, eb_q;
   logic signed [IN_WIDTH:0]    d_q, d_d;
   logic signed [AW-1:0]        acc_q, acc_d;
   logic signed [AW-1:0]        ea_x, eb_x, dw_x, dq_x, start;
   logic signed [AW-1:0]        rs_src, rs_sum, rs_shr;
   logic        [OUT_WIDTH-1:0] out_q, out_d;

   assign ea_x = {{(AW-IN_WIDTH){ea_q[IN_WIDTH-1]}}, ea_q};
   assign eb_x = {{(AW-IN_WIDTH){eb_q[IN_WIDTH-1]}}, eb_q};
   assign dw_x = {{(AW-IN_WIDTH-1){d_d[IN_WIDTH]}}, d_d};
   assign dq_x = {{(AW-IN_WIDTH-1){d_q[IN_WIDTH]}}, d_q};
   assign out_o = out_q;

   // Pilot pair is captured only on the input handshake and held for the whole burst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ea_q <= '0;
         eb_q <= '0;
      end else if (load_i) begin
         ea_q <= ea_i;
         eb_q <= eb_i;
      end
   end

   // Per-step increment; hold mode collapses it to zero so every beat repeats Ea.
   always_comb begin
      d_d = '0;
      if (mode_e'(mode_i) != MODE_HOLD) begin
         d_d = {eb_q[IN_WIDTH-1], eb_q} - {ea_q[IN_WIDTH-1], ea_q};
      end
   end

   // Start position of the burst in SH-bit fixed point.
   always_comb begin
      start = ea_x <<< SH;
      unique case (mode_e'(mode_i))
         MODE_EXTL: start = (ea_x <<< SH) - (dw_x <<< SH);
         MODE_EXTR: start = (eb_x <<< SH) + dw_x;
         default:   start = ea_x <<< SH;
      endcase
   end

   // In DIFF the first beat is produced straight from the start value, so the accumulator
   // is preloaded one step ahead and always holds the value for the next beat.
   always_comb begin
      acc_d = acc_q;
      d_d_unused: begin end
      if (diff_i) begin
         acc_d = start + dw_x;
      end else if (adv_i) begin
         acc_d = acc_q + dq_x;
      end
   end

   // Round half up with arithmetic shift, then clamp to the output range.
   always_comb begin
      rs_src = diff_i ? start : acc_q;
      rs_sum = rs_src + RND;
      rs_shr = rs_sum >>> SH;
      out_d  = out_q;
      if (diff_i || adv_i) begin
         if (rs_shr > SAT_MAX) begin
            out_d = SAT_MAX[OUT_WIDTH-1:0];
         end else if (rs_shr < SAT_MIN) begin
            out_d = SAT_MIN[OUT_WIDTH-1:0];
         end else begin
            out_d = rs_shr[OUT_WIDTH-1:0];
         end
      end
   end

   // Difference, accumulator and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_q   <= '0;
         acc_q <= '0;
         out_q <= '0;
      end else begin
         if (diff_i) begin
            d_q <= d_d;
         end
         acc_q <= acc_d;
         out_q <= out_d;
      end
   end

endmodule

// File: rtl/interp_lerp_engine.sv
// Pilot-pair to STEP-beat linear interp/extrap engine with NUM_CH identical lanes.
// Latency: accept in cycle T gives first out_valid in T+2; then one beat per cycle.
// Backpressure: out_ready low freezes data/idx/last and the accumulators; no input overlap.
module interp_lerp_engine
   import interp_pkg::*;
#(
   parameter int IN_WIDTH  = 17,
   parameter int OUT_WIDTH = 19,
   parameter int NUM_CH    = 2,
   parameter int STEP      = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [1:0]                    mode,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [NUM_CH*IN_WIDTH-1:0]    ea,
   input  logic [NUM_CH*IN_WIDTH-1:0]    eb,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [NUM_CH*OUT_WIDTH-1:0]   out_data,
   output logic [$clog2(STEP)-1:0]       out_idx,
   output logic                          out_last
);

   localparam int SH = $clog2(STEP);
   localparam logic [SH-1:0] IDX_LAST = SH'(STEP - 1);

   state_e          state_q, state_d;
   logic [1:0]      mode_q;
   logic [SH-1:0]   idx_q, idx_d;
   logic            accept, diff, adv;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and handshake decode; in_valid outside IDLE never reaches the datapath.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      diff      = 1'b0;
      adv       = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept  = 1'b1;
               state_d = DIFF;
            end
         end
         DIFF: begin
            diff    = 1'b1;
            state_d = EMIT;
         end
         EMIT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               adv = 1'b1;
               if (idx_q == IDX_LAST) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Beat index: cleared while the lanes load, bumped on every output handshake.
   always_comb begin
      idx_d = idx_q;
      if (diff) begin
         idx_d = '0;
      end else if (adv) begin
         idx_d = idx_q + 1'b1;
      end
   end

   // Mode and index registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q <= MODE_INTERP;
         idx_q  <= '0;
      end else begin
         if (accept) begin
            mode_q <= mode;
         end
         idx_q <= idx_d;
      end
   end

   assign out_idx  = idx_q;
   assign out_last = out_valid && (idx_q == IDX_LAST);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
      interp_lane #(
         .IN_WIDTH  (IN_WIDTH),
         .OUT_WIDTH (OUT_WIDTH),
         .SH        (SH)
      ) u_lane (
         .clk    (clk),
         .rst    (rst),
         .load_i (accept),
         .diff_i (diff),
         .adv_i  (adv),
         .mode_i (mode_q),
         .ea_i   (ea[g*IN_WIDTH +: IN_WIDTH]),
         .eb_i   (eb[g*IN_WIDTH +: IN_WIDTH]),
         .out_o  (out_data[g*OUT_WIDTH +: OUT_WIDTH])
      );
   end

endmodule
